// File: rtl/jpeg_seq_pkg.sv
// Shared types and constants for the JPEG block sequencers (Y, Cb, Cr front ends).
package jpeg_seq_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int BLOCK_AW   = 6;
    localparam logic [BLOCK_AW-1:0] LAST_ADDR = 6'd63;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        GAP   = 2'd2
    } drain_state_e;

    function automatic logic bank_writable(input bank_state_e s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

endpackage

// File: rtl/jpeg_pingpong_bank.sv
// Two 64-entry sample banks: one write port, one registered read port and
// per-bank occupancy state. Reads return 0 whenever no read is issued.
module jpeg_pingpong_bank
    import jpeg_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                wr_en,
    input  logic                wr_bank,
    input  logic [BLOCK_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic                rd_bank,
    input  logic [BLOCK_AW-1:0] rd_addr,
    input  logic                drain_start,
    input  logic                drain_release,
    output logic [DATA_W-1:0]   rd_data,
    output bank_state_e         bank_state [2],
    output bank_state_e         bank_state_nxt [2]
);

    logic [DATA_W-1:0] mem_r [2*BLOCK_SIZE];
    logic [DATA_W-1:0] rd_data_r;
    bank_state_e       bank_state_r [2];
    bank_state_e       bank_state_nxt_s [2];

    // Sample storage; contents are don't-care until a bank is refilled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Registered read port, forced to 0 when idle so the pipeline sees clean zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= '0;
        end else if (clear || !rd_en) begin
            rd_data_r <= '0;
        end else begin
            rd_data_r <= mem_r[{rd_bank, rd_addr}];
        end
    end

    // Next bank state: release beats start beats a write on the same bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_nxt_s[b] = bank_state_r[b];
            if (clear) begin
                bank_state_nxt_s[b] = EMPTY;
            end else if (drain_release && (rd_bank == 1'(b))) begin
                bank_state_nxt_s[b] = EMPTY;
            end else if (drain_start && (rd_bank == 1'(b))) begin
                bank_state_nxt_s[b] = DRAINING;
            end else if (wr_en && (wr_bank == 1'(b))) begin
                bank_state_nxt_s[b] = (wr_addr == LAST_ADDR) ? FULL : FILLING;
            end else begin
                bank_state_nxt_s[b] = bank_state_r[b];
            end
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_state_r[0] <= EMPTY;
            bank_state_r[1] <= EMPTY;
        end else begin
            bank_state_r[0] <= bank_state_nxt_s[0];
            bank_state_r[1] <= bank_state_nxt_s[1];
        end
    end

    assign rd_data           = rd_data_r;
    assign bank_state[0]     = bank_state_r[0];
    assign bank_state[1]     = bank_state_r[1];
    assign bank_state_nxt[0] = bank_state_nxt_s[0];
    assign bank_state_nxt[1] = bank_state_nxt_s[1];

endmodule

// File: rtl/cb_block_sequencer.sv
// Cb front end: ping-pong buffers upstream samples and replays whole 8x8 blocks
// as 64 contiguous enable cycles plus an idle gap. CB_SEQ_STATS_EN enables counters.
module cb_block_sequencer
    import jpeg_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              dct_enable,
    output logic [DATA_W-1:0] dct_data,
    output logic              block_start,
    output logic              busy,
    output logic [15:0]       blocks_done,
    output logic [15:0]       stall_cycles
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    logic [BLOCK_AW-1:0] wr_ptr_r;
    logic [BLOCK_AW-1:0] rd_ptr_r;
    logic                wr_sel_r;
    logic                rd_sel_r;
    logic                s_ready_r;
    logic                dct_enable_r;
    logic                block_start_r;
    logic                busy_r;
    logic [7:0]          gap_cnt_r;
    drain_state_e        state_r;

    logic                hs_s;
    logic                wr_last_s;
    logic                wr_sel_nxt_s;
    logic                gap_done_s;
    logic                full_now_s;
    logic                drain_go_s;
    logic                rd_en_s;
    logic                drain_release_s;
    logic                fsm_idle_nxt_s;
    logic                bank_busy_nxt_s;
    logic                s_ready_nxt_s;
    logic [DATA_W-1:0]   rd_data_s;
    bank_state_e         bank_state_s [2];
    bank_state_e         bank_state_nxt_s [2];

    // Handshake and drain decisions; a fill finishing as GAP ends counts as FULL.
    always_comb begin
        hs_s            = s_valid & s_ready_r & ~clear;
        wr_last_s       = hs_s & (wr_ptr_r == LAST_ADDR);
        wr_sel_nxt_s    = clear ? 1'b0 : (wr_sel_r ^ wr_last_s);
        gap_done_s      = (state_r == GAP) & (gap_cnt_r == GAP_LAST);
        full_now_s      = (bank_state_s[rd_sel_r] == FULL) |
                          (wr_last_s & (wr_sel_r == rd_sel_r));
        drain_go_s      = ~clear & (((state_r == IDLE) & (bank_state_s[rd_sel_r] == FULL)) |
                                    (gap_done_s & full_now_s));
        rd_en_s         = ~clear & (state_r == DRAIN);
        drain_release_s = rd_en_s & (rd_ptr_r == LAST_ADDR);
        fsm_idle_nxt_s  = clear | (((state_r == IDLE) | gap_done_s) & ~drain_go_s);
        bank_busy_nxt_s = (bank_state_nxt_s[0] != EMPTY) | (bank_state_nxt_s[1] != EMPTY);
        s_ready_nxt_s   = bank_writable(bank_state_nxt_s[wr_sel_nxt_s]);
    end

    jpeg_pingpong_bank #(
        .DATA_W (DATA_W)
    ) u_bank (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .wr_en          (hs_s),
        .wr_bank        (wr_sel_r),
        .wr_addr        (wr_ptr_r),
        .wr_data        (s_data),
        .rd_en          (rd_en_s),
        .rd_bank        (rd_sel_r),
        .rd_addr        (rd_ptr_r),
        .drain_start    (drain_go_s),
        .drain_release  (drain_release_s),
        .rd_data        (rd_data_s),
        .bank_state     (bank_state_s),
        .bank_state_nxt (bank_state_nxt_s)
    );

    // Write side: pointer, bank select and the registered ready/busy flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= 6'd0;
            wr_sel_r  <= 1'b0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            if (clear) begin
                wr_ptr_r <= 6'd0;
            end else if (hs_s) begin
                wr_ptr_r <= wr_ptr_r + 6'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            wr_sel_r  <= wr_sel_nxt_s;
            s_ready_r <= s_ready_nxt_s;
            busy_r    <= bank_busy_nxt_s | ~fsm_idle_nxt_s;
        end
    end

    // Drain FSM; enable/start are registered alongside the bank read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            rd_ptr_r      <= 6'd0;
            rd_sel_r      <= 1'b0;
            gap_cnt_r     <= 8'd0;
            dct_enable_r  <= 1'b0;
            block_start_r <= 1'b0;
        end else if (clear) begin
            state_r       <= IDLE;
            rd_ptr_r      <= 6'd0;
            rd_sel_r      <= 1'b0;
            gap_cnt_r     <= 8'd0;
            dct_enable_r  <= 1'b0;
            block_start_r <= 1'b0;
        end else begin
            dct_enable_r  <= rd_en_s;
            block_start_r <= rd_en_s & (rd_ptr_r == 6'd0);
            case (state_r)
                IDLE: begin
                    if (drain_go_s) begin
                        state_r  <= DRAIN;
                        rd_ptr_r <= 6'd0;
                    end
                end
                DRAIN: begin
                    rd_ptr_r <= rd_ptr_r + 6'd1;
                    if (drain_release_s) begin
                        state_r   <= GAP;
                        rd_sel_r  <= ~rd_sel_r;
                        gap_cnt_r <= 8'd0;
                    end
                end
                GAP: begin
                    if (gap_done_s) begin
                        state_r  <= drain_go_s ? DRAIN : IDLE;
                        rd_ptr_r <= 6'd0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef CB_SEQ_STATS_EN
    logic [15:0] blocks_done_r;
    logic [15:0] stall_cycles_r;

    // Statistics survive clear; blocks wrap, stalls saturate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blocks_done_r  <= 16'd0;
            stall_cycles_r <= 16'd0;
        end else begin
            if (drain_release_s) begin
                blocks_done_r <= blocks_done_r + 16'd1;
            end
            if (s_valid && !s_ready_r && (stall_cycles_r != 16'hFFFF)) begin
                stall_cycles_r <= stall_cycles_r + 16'd1;
            end
        end
    end

    assign blocks_done  = blocks_done_r;
    assign stall_cycles = stall_cycles_r;
`else
    assign blocks_done  = 16'd0;
    assign stall_cycles = 16'd0;
`endif

    assign s_ready     = s_ready_r;
    assign dct_enable  = dct_enable_r;
    assign dct_data    = rd_data_s;
    assign block_start = block_start_r;
    assign busy        = busy_r;

endmodule

// File: doc/cb_block_sequencer.md
# cb_block_sequencer

Front-end controller for the Cb DCT/quantiser/Huffman pipeline. It accepts Cb samples from the colour-conversion stage over a valid/ready handshake into a two-bank ping-pong buffer of 64-byte blocks. It then replays each full block to the pipeline as exactly 64 back-to-back `enable`-qualified bytes, followed by a guaranteed idle gap. Upstream stalls therefore never tear an 8x8 block presented to the DCT.

## Interface
- `GAP_CYCLES`, 1: minimum cycles with `dct_enable` low between blocks; legal range 1..255.
- `DATA_W`, 8: sample width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low; synchronous release is the integrator's responsibility.
- `clear` in 1: synchronous flush; empties both banks and aborts any drain.
- `s_valid` in 1: upstream sample valid.
- `s_data` in DATA_W: Cb sample; raster order within the 8x8 block.
- `s_ready` out 1: buffer can accept a sample this cycle.
- `dct_enable` out 1: drives the pipeline `enable`; high for 64 consecutive cycles per block.
- `dct_data` out DATA_W: drives the pipeline `data_in`; valid when `dct_enable` is high, 0 otherwise.
- `block_start` out 1: one-cycle pulse coincident with the first byte of each block.
- `busy` out 1: any bank non-empty, or a drain/gap in progress.
- `blocks_done` out 16: completed drained blocks; wraps.
- `stall_cycles` out 16: cycles with `s_valid & ~s_ready`; saturates at 0xFFFF.

## Operation
- Two banks of 64 x DATA_W. Each bank is EMPTY, FILLING, FULL or DRAINING.
- Write side: `wr_sel` picks the bank and `wr_ptr` (6 bits) gives the address.
  - Each handshake (`s_valid & s_ready` at a rising edge) stores `s_data` and increments `wr_ptr`.
  - When the pointer wraps 63->0, the bank becomes FULL and `wr_sel` toggles.
- `s_ready` = 1 when bank[`wr_sel`] is EMPTY or FILLING. It is registered, so it reflects the state after the edge.
- Drain FSM has three states: IDLE, DRAIN, GAP.
  - IDLE -> DRAIN when bank[`rd_sel`] is FULL.
  - DRAIN issues reads at addresses 0..63 (`rd_ptr`). Bank read data is registered, so the outputs lag the address by one cycle.
  - DRAIN -> GAP after address 63 is issued. At that edge the bank is released to EMPTY and `rd_sel` toggles.
  - GAP counts GAP_CYCLES cycles of `dct_enable` low.
  - At the end of GAP: go to DRAIN if bank[`rd_sel`] is FULL, else IDLE.
- `blocks_done` increments on the cycle the 64th byte is presented.
- `clear`: both banks go EMPTY; pointers, `rd_sel` and `wr_sel` go to 0; FSM goes to IDLE; `dct_enable` drops on the next edge.
  - `clear` wins over a simultaneous handshake; that byte is discarded.
  - Statistics counters are not cleared.
- The write path to a bank and the read path from the other bank operate independently in the same cycle.
- A bank completing fill on the same edge as GAP ends is seen as FULL on that edge, so the next DRAIN starts with no extra idle cycle.

## Timing
- Reset values: `s_ready`=0, `dct_enable`=0, `dct_data`=0, `block_start`=0, `busy`=0, `blocks_done`=0, `stall_cycles`=0.
- `s_ready` rises on the first edge after `rst` deasserts.
- Fill-to-output latency:
  - The 64th handshake occurs at edge E0.
  - The FSM enters DRAIN at E1.
  - `dct_enable`, `block_start` and byte 0 appear after E2.
  - The last byte appears after E65.
- Back-to-back blocks (next bank already FULL): `dct_enable` is low for exactly GAP_CYCLES cycles.
- Throughput bound: one block per 64+GAP_CYCLES cycles.
  - Upstream sees `s_ready` low only when both banks are FULL or DRAINING.
- Reset asserted mid-block: all outputs return to reset values immediately (asynchronously) and buffered data is discarded. The pipeline relies on `dct_enable` low to abandon the partial block.

## Configuration
- `CB_SEQ_STATS_EN` defined: `blocks_done` and `stall_cycles` are implemented as specified.
- `CB_SEQ_STATS_EN` undefined: both ports stay present, tied to 0, and the counter logic is absent.

## Structure
- Package `jpeg_seq_pkg` holds:
  - `BLOCK_SIZE`=64 and `BLOCK_AW`=6.
  - Typedef `bank_state_e` (EMPTY, FILLING, FULL, DRAINING).
  - Typedef `drain_state_e` (IDLE, DRAIN, GAP).
- One sub-module, `jpeg_pingpong_bank`: 2x64 x DATA_W storage with one write port, one registered read port, and per-bank state flags.
- The same sequencer is reused in front of the Y and Cr pipelines.

## Test plan
- Reset release, then 64 bytes 0..63 presented continuously:
  - `dct_enable` high for 64 cycles starting 2 cycles after the last handshake.
  - `dct_data` = 0..63 in order; `block_start` pulses once; `blocks_done`=1.
- 192 bytes presented continuously with GAP_CYCLES=3:
  - Three 64-cycle bursts separated by exactly 3 low cycles.
  - `s_ready` drops while both banks are busy; `stall_cycles` > 0.
- Upstream `s_valid` toggling every other cycle through one block: output burst still 64 contiguous cycles with correct data.
- `clear` asserted at byte 40 of a drain while the other bank is half-filled:
  - `dct_enable` low on the next edge; `busy`=0.
  - The next 64 bytes produce a clean block starting at byte 0.
- `rst` pulsed low for 1 cycle mid-burst:
  - Outputs go to 0 immediately; `blocks_done`=0.
  - Operation resumes normally after release.
- Without `CB_SEQ_STATS_EN`, repeat the 192-byte test: identical bursts; `blocks_done` and `stall_cycles` read 0.
